// File: rtl/jt900h_ldx_pkg.sv
// Shared definitions for the LDI/LDIR/LDD/LDDR block-transfer sequencer:
// FSM state encoding and the register-file read/write selector codes.
package jt900h_ldx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LD_HL = 4'd1,
        ST_LD_DE = 4'd2,
        ST_LD_BC = 4'd3,
        ST_RD    = 4'd4,
        ST_WR    = 4'd5,
        ST_WB_HL = 4'd6,
        ST_WB_DE = 4'd7,
        ST_WB_BC = 4'd8,
        ST_CHK   = 4'd9
    } ldx_state_t;

    // The register-file mux decodes these same codes.
    localparam logic [1:0] XHL_SEL = 2'd0;
    localparam logic [1:0] XDE_SEL = 2'd1;
    localparam logic [1:0] BC_SEL  = 2'd2;

endpackage

// File: rtl/jt900h_ldx_step.sv
// Pointer stepper: adds or subtracts 1 (byte) or 2 (word), wrapping modulo 2^AW.
// Odd addresses are stepped as-is; no alignment is applied.
module jt900h_ldx_step #(
    parameter int AW = 24
) (
    input  logic [AW-1:0] i_ptr,
    input  logic          i_ws,
    input  logic          i_dec,
    output logic [AW-1:0] o_ptr
);

    logic [AW-1:0] w_step;

    always_comb begin
        w_step = i_ws ? AW'(2) : AW'(1);
        o_ptr  = i_dec ? (i_ptr - w_step) : (i_ptr + w_step);
    end

endmodule

// File: rtl/jt900h_ldx_seq.sv
// TLCS-900H block-transfer sequencer: fetches XHL/XDE/BC through the register
// file, moves one byte or word over the bus, writes back pointers, BC and V.
module jt900h_ldx_seq
    import jt900h_ldx_pkg::*;
#(
    parameter int AW = 24,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          start,
    input  logic          ws,
    input  logic          dec,
    input  logic          rep,
    input  logic          irq,
    output logic          busy,
    output logic          done,
    output logic          susp,
    output logic [1:0]    reg_sel,
    input  logic [31:0]   reg_din,
    output logic          reg_we,
    output logic [31:0]   reg_dout,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_dout,
    input  logic [DW-1:0] mem_din,
    input  logic          mem_ack,
    output logic          flag_we,
    output logic          flag_v
);

    ldx_state_t    r_state;
    ldx_state_t    w_next;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [15:0]   r_cnt;
    logic [DW-1:0] r_data;
    logic          r_ws;
    logic          r_dec;
    logic          r_rep;
    logic [AW-1:0] w_src_nx;
    logic [AW-1:0] w_dst_nx;
    logic [15:0]   w_cnt_m1;
    logic          w_unused;

    // Upper XHL/XDE bits beyond the bus width are not part of the address.
    assign w_unused = ^reg_din[31:AW];
    assign w_cnt_m1 = r_cnt - 16'd1;

    jt900h_ldx_step #(.AW(AW)) u_step_src (
        .i_ptr (r_src),
        .i_ws  (r_ws),
        .i_dec (r_dec),
        .o_ptr (w_src_nx)
    );

    jt900h_ldx_step #(.AW(AW)) u_step_dst (
        .i_ptr (r_dst),
        .i_ws  (r_ws),
        .i_dec (r_dec),
        .o_ptr (w_dst_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_ws    <= 1'b0;
            r_dec   <= 1'b0;
            r_rep   <= 1'b0;
        end else if (cen) begin
            r_state <= w_next;
            case (r_state)
                // Transfer mode is frozen for the whole instruction.
                ST_IDLE:  if (start) begin
                              r_ws  <= ws;
                              r_dec <= dec;
                              r_rep <= rep;
                          end
                ST_LD_HL: r_src <= reg_din[AW-1:0];
                ST_LD_DE: r_dst <= reg_din[AW-1:0];
                ST_LD_BC: r_cnt <= reg_din[15:0];
                ST_RD:    if (mem_ack) r_data <= r_ws ? mem_din : DW'(mem_din[7:0]);
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b1;
        done     = 1'b0;
        susp     = 1'b0;
        reg_sel  = XHL_SEL;
        reg_we   = 1'b0;
        reg_dout = '0;
        mem_addr = '0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_dout = '0;
        flag_we  = 1'b0;
        flag_v   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_next = ST_LD_HL;
            end
            ST_LD_HL: begin
                reg_sel = XHL_SEL;
                w_next  = ST_LD_DE;
            end
            ST_LD_DE: begin
                reg_sel = XDE_SEL;
                w_next  = ST_LD_BC;
            end
            ST_LD_BC: begin
                reg_sel = BC_SEL;
                w_next  = ST_RD;
            end
            ST_RD: begin
                mem_addr = r_src;
                mem_rd   = 1'b1;
                if (mem_ack) w_next = ST_WR;
            end
            ST_WR: begin
                mem_addr = r_dst;
                mem_wr   = 1'b1;
                mem_dout = r_data;
                if (mem_ack) w_next = ST_WB_HL;
            end
            ST_WB_HL: begin
                reg_sel  = XHL_SEL;
                reg_we   = 1'b1;
                reg_dout = 32'(w_src_nx);
                w_next   = ST_WB_DE;
            end
            ST_WB_DE: begin
                reg_sel  = XDE_SEL;
                reg_we   = 1'b1;
                reg_dout = 32'(w_dst_nx);
                w_next   = ST_WB_BC;
            end
            ST_WB_BC: begin
                reg_sel  = BC_SEL;
                reg_we   = 1'b1;
                reg_dout = {16'd0, w_cnt_m1};
                flag_we  = 1'b1;
                flag_v   = (w_cnt_m1 != 16'd0);
                w_next   = ST_CHK;
            end
            ST_CHK: begin
                // Interrupts are only taken between iterations of the repeat form.
                if (!r_rep || (w_cnt_m1 == 16'd0)) begin
                    done   = 1'b1;
                    w_next = ST_IDLE;
                end else if (irq) begin
                    done   = 1'b1;
                    susp   = 1'b1;
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_LD_HL;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_jt900h_ldx_seq.sv
// Bench for jt900h_ldx_seq: register-file and memory environment plus a
// transfer-level reference model of the LDI/LDIR/LDD/LDDR family.
module tb_jt900h_ldx_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen = 1'b0;
    logic        start, ws, dec, rep, irq;
    logic        busy, done, susp;
    logic [1:0]  reg_sel;
    logic [31:0] reg_din;
    logic        reg_we;
    logic [31:0] reg_dout;
    logic [23:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_dout;
    logic [15:0] mem_din = 16'h0;
    logic        mem_ack = 1'b0;
    logic        flag_we, flag_v;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rf [4];
    logic [7:0]  mem [int unsigned];
    logic [39:0] wr_q [$];

    int          ack_delay = 0;
    bit          cen_mode  = 1'b0;
    bit          snap_en   = 1'b0;
    int          n_we = 0, n_fwe = 0, n_done = 0;
    logic        v_last = 1'b0, susp_last = 1'b0;

    always #5 clk = ~clk;

    assign reg_din = rf[reg_sel];

    jt900h_ldx_seq #(.AW(24), .DW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .start    (start),
        .ws       (ws),
        .dec      (dec),
        .rep      (rep),
        .irq      (irq),
        .busy     (busy),
        .done     (done),
        .susp     (susp),
        .reg_sel  (reg_sel),
        .reg_din  (reg_din),
        .reg_we   (reg_we),
        .reg_dout (reg_dout),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_dout (mem_dout),
        .mem_din  (mem_din),
        .mem_ack  (mem_ack),
        .flag_we  (flag_we),
        .flag_v   (flag_v)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [23:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [15:0] rd_word(input logic [23:0] a);
        return {rd_byte(a + 24'd1), rd_byte(a)};
    endfunction

    // Environment: clock enable, bus responder, register file and strobe capture.
    initial begin : env
        bit          req_act = 1'b0;
        bit          req_wr  = 1'b0;
        logic [23:0] req_addr = '0;
        logic [15:0] req_data = '0;
        int          wcnt = 0;
        logic [62:0] snap = '0;
        forever begin
            @(negedge clk);
            if (snap_en && !cen)
                chk("cen0_hold", 64'({busy, reg_we, reg_sel, mem_rd, mem_wr, flag_we, mem_addr, reg_dout}),
                    64'(snap));
            snap = {busy, reg_we, reg_sel, mem_rd, mem_wr, flag_we, mem_addr, reg_dout};
            cen = cen_mode ? ~cen : 1'b1;
            if (rst_n && (mem_rd || mem_wr)) begin
                if (req_act && (req_wr == mem_wr)) begin
                    chk("req_addr_stable", 64'(mem_addr), 64'(req_addr));
                    if (mem_wr) chk("req_data_stable", 64'(mem_dout), 64'(req_data));
                    wcnt++;
                end else begin
                    req_act  = 1'b1;
                    req_wr   = mem_wr;
                    req_addr = mem_addr;
                    req_data = mem_dout;
                    wcnt     = 0;
                end
                if (wcnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_rd) mem_din = rd_word(mem_addr);
                end else begin
                    mem_ack = 1'b0;
                end
                if (mem_ack && cen) begin
                    if (mem_wr) begin
                        wr_q.push_back({mem_addr, mem_dout});
                        mem[int'(mem_addr)] = mem_dout[7:0];
                        if (ws) mem[int'(mem_addr + 24'd1)] = mem_dout[15:8];
                    end
                    req_act = 1'b0;
                end
            end else begin
                req_act = 1'b0;
                mem_ack = 1'b0;
            end
            if (rst_n && cen) begin
                if (reg_we) begin
                    rf[reg_sel] = reg_dout;
                    n_we++;
                end
                if (flag_we) begin
                    v_last = flag_v;
                    n_fwe++;
                end
                if (done) begin
                    susp_last = susp;
                    n_done++;
                end
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        start = 1'b0;
        chk("start_ack", 64'(busy), 64'd1);
    endtask

    // One instruction: predict its transfers from the architectural rules,
    // run it, then compare bus writes, registers, flags and completion.
    task automatic run(input string nm, input logic [23:0] h0, input logic [23:0] d0,
                       input logic [15:0] c0, input logic w, input logic dc, input logic rp,
                       input logic ir, input int dly,
                       output logic [23:0] h_o, output logic [23:0] d_o, output logic [15:0] c_o);
        logic [23:0] h, d, st;
        logic [15:0] c, dat;
        logic [39:0] exp_q [$];
        int          it, done0, fwe0, nmin;
        logic        sp;
        h = h0; d = d0; c = c0; it = 0; sp = 1'b0;
        st = w ? 24'd2 : 24'd1;
        while (1) begin
            dat = w ? rd_word(h) : {8'h00, rd_byte(h)};
            exp_q.push_back({d, dat});
            h = dc ? h - st : h + st;
            d = dc ? d - st : d + st;
            c = c - 16'd1;
            it++;
            if (!rp || c == 16'd0) break;
            if (ir) begin
                sp = 1'b1;
                break;
            end
        end
        rf[0] = {8'h00, h0};
        rf[1] = {8'h00, d0};
        rf[2] = {16'h0000, c0};
        ws = w; dec = dc; rep = rp; irq = 1'b0; ack_delay = dly;
        wr_q.delete();
        done0 = n_done;
        fwe0  = n_fwe;
        do_start();
        irq = ir;
        for (int i = 0; i < 3000 && n_done == done0; i++) @(negedge clk);
        chk({nm, "_done_seen"}, 64'(n_done != done0), 64'd1);
        repeat (4) @(negedge clk);
        chk({nm, "_done_once"}, 64'(n_done - done0), 64'd1);
        chk({nm, "_susp"}, 64'(susp_last), 64'(sp));
        chk({nm, "_xhl"}, 64'(rf[0]), 64'({8'h00, h}));
        chk({nm, "_xde"}, 64'(rf[1]), 64'({8'h00, d}));
        chk({nm, "_bc"}, 64'(rf[2]), 64'({16'h0000, c}));
        chk({nm, "_v"}, 64'(v_last), 64'(c != 16'd0));
        chk({nm, "_flag_we_cnt"}, 64'(n_fwe - fwe0), 64'(it));
        chk({nm, "_wr_cnt"}, 64'(wr_q.size()), 64'(exp_q.size()));
        nmin = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) chk({nm, "_wr"}, 64'(wr_q[i]), 64'(exp_q[i]));
        chk({nm, "_idle"}, 64'(busy), 64'd0);
        irq = 1'b0;
        h_o = h; d_o = d; c_o = c;
    endtask

    initial begin : main
        logic [23:0] h, d, hs, ds;
        logic [15:0] c;
        int          n_we0;
        rst_n = 1'b0; start = 1'b0; ws = 1'b0; dec = 1'b0; rep = 1'b0; irq = 1'b0;
        for (int i = 0; i < 4; i++) rf[i] = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mem", 64'({mem_rd, mem_wr, mem_addr, mem_dout}), 64'd0);
        chk("rst_reg", 64'({reg_we, reg_sel, reg_dout}), 64'd0);
        chk("rst_flag", 64'({flag_we, flag_v, susp}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 64'({busy, done, reg_we, mem_rd, mem_wr}), 64'd0);

        // LDI byte
        mem[32'h1000] = 8'hAB; mem[32'h1001] = 8'hCD;
        run("ldi_b", 24'h001000, 24'h002000, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, h, d, c);
        chk("ldi_b_xhl_const", 64'(rf[0]), 64'h0000_1001);
        chk("ldi_b_data_const", 64'(wr_q.size() > 0 ? wr_q[0] : 40'h0), 64'h0020_0000_AB);

        // LDIR word, BC=2
        run("ldir_w", 24'h000100, 24'h000200, 16'd2, 1'b1, 1'b0, 1'b1, 1'b0, 0, h, d, c);
        chk("ldir_w_xde_const", 64'(rf[1]), 64'h0000_0204);

        // LDD byte with BC=0 and XHL=0 wraps both
        run("ldd_b0", 24'h000000, 24'h000500, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1, h, d, c);
        chk("ldd_b0_bc_const", 64'(rf[2]), 64'h0000_FFFF);
        chk("ldd_b0_xhl_const", 64'(rf[0]), 64'h00FF_FFFF);
        run("ldd_w_odd", 24'h000000, 24'h000301, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0, 0, h, d, c);
        chk("ldd_w_xhl_const", 64'(rf[0]), 64'h00FF_FFFE);
        run("ldi_wrap", 24'hFFFFFF, 24'h000400, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2, h, d, c);
        chk("ldi_wrap_xhl_const", 64'(rf[0]), 64'h0000_0000);

        // LDIR byte suspended by irq, then resumed
        run("ldir_irq", 24'h010000, 24'h020000, 16'd5, 1'b0, 1'b0, 1'b1, 1'b1, 0, h, d, c);
        chk("ldir_irq_bc_const", 64'(rf[2]), 64'h0000_0004);
        run("ldir_resume", h, d, c, 1'b0, 1'b0, 1'b1, 1'b0, 0, h, d, c);
        chk("ldir_resume_bc_const", 64'(rf[2]), 64'h0000_0000);

        // Delayed ack with cen toggling
        cen_mode = 1'b1;
        @(negedge clk);
        snap_en = 1'b1;
        run("cen_slow", 24'h040000, 24'h050000, 16'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3, h, d, c);
        snap_en = 1'b0;
        cen_mode = 1'b0;
        @(negedge clk);

        // Randomized transfers
        for (int k = 0; k < 6; k++) begin
            hs = 24'h100000 + 24'($urandom_range(32, 4000));
            ds = 24'h300000 + 24'($urandom_range(32, 4000));
            for (int i = -16; i <= 16; i++) mem[int'(hs + 24'(i))] = 8'($urandom);
            run("rnd", hs, ds, 16'($urandom_range(1, 6)), 1'($urandom), 1'($urandom),
                1'($urandom), 1'b0, $urandom_range(0, 2), h, d, c);
        end

        // Asynchronous reset while waiting in WR
        rf[0] = 32'h0000_6000; rf[1] = 32'h0000_7000; rf[2] = 32'h0000_0003;
        ws = 1'b0; dec = 1'b0; rep = 1'b1; irq = 1'b0; ack_delay = 30;
        do_start();
        for (int i = 0; i < 200 && !mem_wr; i++) @(negedge clk);
        chk("rst_reach_wr", 64'(mem_wr), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_mem", 64'({mem_rd, mem_wr, mem_addr, mem_dout}), 64'd0);
        chk("arst_reg", 64'({reg_we, reg_dout, flag_we, done}), 64'd0);
        n_we0 = n_we;
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        repeat (20) @(negedge clk);
        chk("arst_no_we", 64'(n_we - n_we0), 64'd0);
        chk("arst_idle", 64'(busy), 64'd0);
        run("post_arst", 24'h006000, 24'h007000, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 0, h, d, c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
